// File: rtl/multicycle_controller.sv
// Purpose: sequences the shared RV32I multi-cycle datapath by driving PC, IR, ALU, immediate and memory controls each cycle.
// Latency: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5 cycles with mem_ready high; each mem_ready-low cycle adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low, with no enable pulses except the held mem_write.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   op, funct3, funct7_5        instruction fields from the instruction register
//   zero, lt, ltu               ALU flags used to resolve branches
//   mem_ready                   unified memory completes the current access this cycle
//   pc_write, ir_write, reg_write, mem_write, adr_src   datapath enables and memory address select
//   result_src, alu_src_a, alu_src_b, alu_control, imm_src   datapath selects
//   instr_done                  one-cycle retire pulse
//   illegal                     sticky trap flag, cleared only by reset
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADDR, S_JALR_JUMP, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD, ALU_SUB, ALU_FUNCT
    } alu_op_e;

    // State-only (Moore) part of the control word; registered from the next state.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       instr_done;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_e    alu_op;
    } ctl_t;

    state_t state_q, state_d, decode_next;
    ctl_t   ctl_q;
    logic   illegal_q;
    logic   taken;

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR_ADDR, S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                if (s == S_EXECI) c.alu_op = ALU_FUNCT;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 2'b10;
                c.alu_op     = ALU_SUB;
                c.instr_done = 1'b1;
            end
            S_JAL, S_JALR_JUMP: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Opcode dispatch with the unsupported-encoding checks folded in.
    always_comb begin
        decode_next = S_TRAP;
        case (op)
            OP_LOAD, OP_STORE: if (funct3 == 3'b010) decode_next = S_MEMADR;
            OP_R: begin
                if (funct3 != 3'b001 && funct3 != 3'b101 && !(funct7_5 && funct3 != 3'b000))
                    decode_next = S_EXECR;
            end
            OP_I:      if (funct3 != 3'b001 && funct3 != 3'b101) decode_next = S_EXECI;
            OP_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) decode_next = S_BRANCH;
            OP_JAL:    decode_next = S_JAL;
            OP_JALR:   if (funct3 == 3'b000) decode_next = S_JALR_ADDR;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = decode_next;
            S_MEMADR:    state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:     state_d = S_FETCH;
            S_MEMWRITE:  if (mem_ready) state_d = S_FETCH;
            S_EXECR:     state_d = S_ALUWB;
            S_EXECI:     state_d = S_ALUWB;
            S_ALUWB:     state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALUWB;
            S_JALR_ADDR: state_d = S_JALR_JUMP;
            S_JALR_JUMP: state_d = S_ALUWB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctl_q     <= ctl_of(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_of(state_d);
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (ctl_q.alu_op)
            ALU_SUB: alu_control = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    // Only the register form uses funct7_5 as a subtract select; in op-imm it is an immediate bit.
                    3'b000:  alu_control = (op == OP_R && funct7_5) ? 3'b001 : 3'b000;
                    3'b100:  alu_control = 3'b100;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    3'b010:  alu_control = 3'b101;
                    3'b011:  alu_control = 3'b110;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // Handshake-dependent enables are gated here; reset masks every enable in the same cycle.
    assign pc_write   = !reset && (ctl_q.pc_write
                                   || (state_q == S_FETCH && mem_ready)
                                   || (state_q == S_BRANCH && taken));
    assign ir_write   = !reset && state_q == S_FETCH && mem_ready;
    assign mem_write  = !reset && ctl_q.mem_write;
    assign reg_write  = !reset && ctl_q.reg_write;
    assign instr_done = !reset && (ctl_q.instr_done || (state_q == S_MEMWRITE && mem_ready));
    assign adr_src    = ctl_q.adr_src;
    assign result_src = ctl_q.result_src;
    assign alu_src_a  = ctl_q.alu_src_a;
    assign alu_src_b  = ctl_q.alu_src_b;
    assign illegal    = illegal_q;

endmodule
